// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared constants and FSM state type for the VGA text-mode VRAM path
package vga_text_pkg;
   localparam int ADDR_W       = 10;
   localparam int DATA_W       = 32;
   localparam int NUM_WORDS    = 601;
   localparam int CTRL_REG     = 600;
   localparam int STARVE_LIMIT = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_AVL_RD,
      S_AVL_DONE
   } state_e;
endpackage

// File: rtl/starve_counter.sv
// rtl/starve_counter.sv - saturating counter of cycles a pending Avalon access has lost arbitration
module starve_counter #(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);
   localparam int CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      at_limit = (cnt_q == CNT_W'(LIMIT));
      cnt_d    = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !at_limit) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/vram_access_arbiter.sv
// rtl/vram_access_arbiter.sv - arbitrates the single-port VRAM between display fetch and the Avalon slave
module vram_access_arbiter #(
   parameter int ADDR_W       = vga_text_pkg::ADDR_W,
   parameter int DATA_W       = vga_text_pkg::DATA_W,
   parameter int NUM_WORDS    = vga_text_pkg::NUM_WORDS,
   parameter int STARVE_LIMIT = vga_text_pkg::STARVE_LIMIT
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              AVL_CS,
   input  logic              AVL_READ,
   input  logic              AVL_WRITE,
   input  logic [3:0]        AVL_BYTE_EN,
   input  logic [ADDR_W-1:0] AVL_ADDR,
   input  logic [DATA_W-1:0] AVL_WRITEDATA,
   output logic [DATA_W-1:0] AVL_READDATA,
   output logic              AVL_WAITREQUEST,
   input  logic              DISP_REQ,
   input  logic [ADDR_W-1:0] DISP_ADDR,
   output logic              DISP_GNT,
   output logic              DISP_VALID,
   output logic [DATA_W-1:0] DISP_RDATA,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic              RAM_WE,
   output logic [3:0]        RAM_BE,
   output logic [DATA_W-1:0] RAM_WDATA,
   input  logic [DATA_W-1:0] RAM_RDATA
);
   import vga_text_pkg::*;

   localparam logic [ADDR_W:0] NUM_WORDS_W = (ADDR_W + 1)'(NUM_WORDS);

   state_e              state_q, state_d;
   logic                disp_valid_q, disp_valid_d;
   logic [DATA_W-1:0]   disp_rdata_q, disp_rdata_d;
   logic [DATA_W-1:0]   avl_readdata_q, avl_readdata_d;

   logic avl_pend, avl_oor, idle, starved;
   logic disp_gnt, avl_gnt, wr_done, rd_gnt, oor_done;
   logic cnt_inc, cnt_clr;

   starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk      (CLK),
      .rst      (RESET),
      .inc      (cnt_inc),
      .clr      (cnt_clr),
      .at_limit (starved)
   );

   // Display wins unless the Avalon side has already lost STARVE_LIMIT cycles in a row.
   always_comb begin
      avl_pend = AVL_CS & (AVL_READ | AVL_WRITE);
      avl_oor  = ({1'b0, AVL_ADDR} >= NUM_WORDS_W);
      idle     = (state_q == S_IDLE);
      disp_gnt = !RESET & DISP_REQ & !(avl_pend & starved);
      oor_done = !RESET & avl_pend & avl_oor & idle;
      avl_gnt  = !RESET & !disp_gnt & avl_pend & !avl_oor & idle;
      wr_done  = avl_gnt & !AVL_READ;
      rd_gnt   = avl_gnt & AVL_READ;
      cnt_inc  = avl_pend & idle & !avl_gnt & !oor_done;
      cnt_clr  = avl_gnt | oor_done | !avl_pend;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (rd_gnt) state_d = S_AVL_RD;
         S_AVL_RD:   state_d = S_AVL_DONE;
         S_AVL_DONE: state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      disp_valid_d   = disp_gnt;
      disp_rdata_d   = disp_valid_q ? RAM_RDATA : disp_rdata_q;
      avl_readdata_d = (state_q == S_AVL_RD) ? RAM_RDATA : avl_readdata_q;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q        <= S_IDLE;
         disp_valid_q   <= 1'b0;
         disp_rdata_q   <= '0;
         avl_readdata_q <= '0;
      end else begin
         state_q        <= state_d;
         disp_valid_q   <= disp_valid_d;
         disp_rdata_q   <= disp_rdata_d;
         avl_readdata_q <= avl_readdata_d;
      end
   end

   // Read data is only driven while the read completes; out-of-range reads therefore see 0.
   always_comb begin
      AVL_READDATA    = (state_q == S_AVL_DONE) ? avl_readdata_q : '0;
      AVL_WAITREQUEST = avl_pend & !wr_done & (state_q != S_AVL_DONE) & !oor_done;
      DISP_GNT        = disp_gnt;
      DISP_VALID      = disp_valid_q;
      DISP_RDATA      = disp_valid_q ? RAM_RDATA : disp_rdata_q;
      RAM_ADDR        = disp_gnt ? DISP_ADDR : AVL_ADDR;
      RAM_WE          = wr_done;
      RAM_BE          = AVL_BYTE_EN;
      RAM_WDATA       = AVL_WRITEDATA;
   end
endmodule

// File: tb/tb_vram_access_arbiter.sv
// tb/tb_vram_access_arbiter.sv - scoreboard bench for the VRAM access arbiter
module tb_vram_access_arbiter;
   logic        CLK = 1'b0;
   logic        RESET;
   logic        AVL_CS, AVL_READ, AVL_WRITE;
   logic [3:0]  AVL_BYTE_EN;
   logic [9:0]  AVL_ADDR;
   logic [31:0] AVL_WRITEDATA, AVL_READDATA;
   logic        AVL_WAITREQUEST;
   logic        DISP_REQ;
   logic [9:0]  DISP_ADDR;
   logic        DISP_GNT, DISP_VALID;
   logic [31:0] DISP_RDATA;
   logic [9:0]  RAM_ADDR;
   logic        RAM_WE;
   logic [3:0]  RAM_BE;
   logic [31:0] RAM_WDATA, RAM_RDATA;

   logic [31:0] mem [0:1023];
   logic [31:0] exp_disp[$];
   logic [31:0] exp_avl[$];
   int errors = 0;
   int checks = 0;

   always #10 CLK = ~CLK;

   vram_access_arbiter dut (
      .CLK(CLK), .RESET(RESET),
      .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
      .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
      .AVL_READDATA(AVL_READDATA), .AVL_WAITREQUEST(AVL_WAITREQUEST),
      .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR), .DISP_GNT(DISP_GNT),
      .DISP_VALID(DISP_VALID), .DISP_RDATA(DISP_RDATA),
      .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE), .RAM_BE(RAM_BE),
      .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA)
   );

   always @(posedge CLK) begin
      if (RAM_WE) begin
         for (int b = 0; b < 4; b++)
            if (RAM_BE[b]) mem[RAM_ADDR][8*b +: 8] <= RAM_WDATA[8*b +: 8];
      end
      RAM_RDATA <= mem[RAM_ADDR];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (!RESET && DISP_VALID) begin
         if (exp_disp.size() == 0) chk("disp_unexpected_valid", 32'd1, 32'd0);
         else chk("disp_rdata", DISP_RDATA, exp_disp.pop_front());
      end
      if (!RESET && AVL_CS && AVL_READ && !AVL_WAITREQUEST) begin
         if (exp_avl.size() == 0) chk("avl_unexpected_done", 32'd1, 32'd0);
         else chk("avl_readdata", AVL_READDATA, exp_avl.pop_front());
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic avl_idle();
      AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
   endtask

   task automatic avl_read(input logic [9:0] addr, input logic [31:0] exp, input string name);
      int lat;
      cyc();
      AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b0; AVL_ADDR = addr;
      exp_avl.push_back(exp);
      lat = -1;
      for (int k = 0; k < 12; k++) begin
         @(negedge CLK);
         if (!AVL_WAITREQUEST) begin
            lat = k;
            break;
         end
         cyc();
      end
      cyc();
      avl_idle();
      chk(name, lat, 32'd2);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[3]   = 32'h33333333;
      mem[5]   = 32'h41424344;
      mem[10]  = 32'h0A0B0C0D;
      mem[20]  = 32'h11112222;
      mem[600] = 32'h12345678;

      RESET = 1'b1;
      DISP_REQ = 1'b1; DISP_ADDR = 10'd5;
      AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_READ = 1'b0; AVL_ADDR = 10'd3;
      AVL_BYTE_EN = 4'hF; AVL_WRITEDATA = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("rst_ram_we", RAM_WE, 0);
         chk("rst_disp_gnt", DISP_GNT, 0);
      end
      cyc();
      RESET = 1'b0; DISP_REQ = 1'b0; avl_idle();
      @(negedge CLK);
      chk("idle_disp_gnt", DISP_GNT, 0);
      chk("idle_disp_valid", DISP_VALID, 0);
      chk("idle_disp_rdata", DISP_RDATA, 0);
      chk("idle_avl_readdata", AVL_READDATA, 0);
      chk("idle_waitrequest", AVL_WAITREQUEST, 0);
      chk("idle_ram_we", RAM_WE, 0);
      chk("rst_no_write_mem3", mem[3], 32'h33333333);

      // display reads, back to back
      cyc();
      DISP_REQ = 1'b1; DISP_ADDR = 10'd5;
      @(negedge CLK);
      chk("disp_gnt_5", DISP_GNT, 1);
      chk("disp_ram_addr_5", RAM_ADDR, 10'd5);
      exp_disp.push_back(32'h41424344);
      cyc();
      DISP_ADDR = 10'd10;
      @(negedge CLK);
      chk("disp_valid_t1", DISP_VALID, 1);
      chk("disp_gnt_10", DISP_GNT, 1);
      chk("disp_ram_addr_10", RAM_ADDR, 10'd10);
      exp_disp.push_back(32'h0A0B0C0D);
      cyc();
      DISP_REQ = 1'b0;
      @(negedge CLK);
      chk("disp_gnt_drop", DISP_GNT, 0);

      // partial write to the control register, then read it back
      cyc();
      AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 10'd600;
      AVL_BYTE_EN = 4'b1100; AVL_WRITEDATA = 32'hDEAD0000;
      @(negedge CLK);
      chk("wr_ram_we", RAM_WE, 1);
      chk("wr_ram_be", RAM_BE, 4'b1100);
      chk("wr_ram_addr", RAM_ADDR, 10'd600);
      chk("wr_waitrequest", AVL_WAITREQUEST, 0);
      cyc();
      avl_idle();
      avl_read(10'd600, 32'hDEAD5678, "rd600_latency");

      // contention: display held, Avalon read starves for STARVE_LIMIT cycles
      cyc();
      DISP_REQ = 1'b1; DISP_ADDR = 10'd20;
      AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 10'd10;
      exp_avl.push_back(32'h0A0B0C0D);
      for (int c = 1; c <= 8; c++) begin
         @(negedge CLK);
         chk($sformatf("cont_disp_gnt_c%0d", c), DISP_GNT, (c != 5));
         chk($sformatf("cont_waitreq_c%0d", c), AVL_WAITREQUEST, (c < 7));
         if (c != 5) exp_disp.push_back(32'h11112222);
         else chk("cont_avl_ram_addr", RAM_ADDR, 10'd10);
         cyc();
         if (c == 7) avl_idle();
      end
      DISP_REQ = 1'b0;

      // out-of-range accesses
      cyc();
      AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 10'd700;
      exp_avl.push_back(32'h0);
      @(negedge CLK);
      chk("oor_rd_waitreq", AVL_WAITREQUEST, 0);
      chk("oor_rd_ram_we", RAM_WE, 0);
      cyc();
      AVL_READ = 1'b0; AVL_WRITE = 1'b1; AVL_ADDR = 10'd601;
      AVL_BYTE_EN = 4'hF; AVL_WRITEDATA = 32'hFFFFFFFF;
      @(negedge CLK);
      chk("oor_wr_ram_we", RAM_WE, 0);
      chk("oor_wr_waitreq", AVL_WAITREQUEST, 0);
      cyc();
      avl_idle();
      @(negedge CLK);
      chk("oor_wr_mem601", mem[601], 32'h0);

      // reset during S_AVL_RD
      cyc();
      AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 10'd5;
      @(negedge CLK);
      chk("mid_grant_waitreq", AVL_WAITREQUEST, 1);
      cyc();
      RESET = 1'b1;
      @(negedge CLK);
      chk("mid_rd_readdata", AVL_READDATA, 0);
      cyc();
      RESET = 1'b0; avl_idle();
      @(negedge CLK);
      chk("mid_post_disp_valid", DISP_VALID, 0);
      chk("mid_post_readdata", AVL_READDATA, 0);
      chk("mid_post_waitreq", AVL_WAITREQUEST, 0);
      avl_read(10'd5, 32'h41424344, "rd_after_reset_latency");

      repeat (3) cyc();
      chk("disp_queue_empty", exp_disp.size(), 0);
      chk("avl_queue_empty", exp_avl.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
